bin_to_dec_seq: RTL and testbench
=================================

// Module: bin_to_dec_seq
// PURPOSE
//  Iterative binary-to-BCD converter with two-requester round-robin arbitration.
//  Shares one double-dabble shift/add-3 datapath between requesters (e.g. register
//  display and PC display); processes one input bit per clock.
//  Sits between processor state and the 7-segment display drivers.
// PARAMETERS
//  WIDTH   32  binary input width; also the number of shift cycles per conversion
//  DIGITS  4   BCD digits produced; digit 0 = units in bcd[3:0]
// PORTS
//  clk        in   1           rising-edge clock
//  rst        in   1           synchronous reset, active-high
//  req0       in   1           requester 0 request; held high with bin0 stable until ack0
//  bin0       in   WIDTH       requester 0 operand
//  req1       in   1           requester 1 request; same rules
//  bin1       in   WIDTH       requester 1 operand
//  ack0       out  1           1-cycle pulse: operand 0 captured
//  ack1       out  1           1-cycle pulse: operand 1 captured
//  busy       out  1           high from capture until the valid cycle, inclusive
//  valid      out  1           1-cycle pulse: bcd/overflow/owner are valid
//  owner      out  1           requester id of the current result
//  bcd        out  4*DIGITS    result digits; held until the next valid
//  overflow   out  1           value needs more than DIGITS digits; held with bcd
// BEHAVIOUR
//  Reset: state=IDLE; ack0=ack1=busy=valid=owner=overflow=0; bcd=0; last=1.
//  - Because last=1, requester 0 wins the first tie.
//  FSM: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE:
//  - If neither req is high, stay in IDLE.
//  - If exactly one req is high, grant that requester.
//  - If both are high, grant the requester != last.
//  - On a grant at edge E0: sr<=bin_g, acc<=0, ovf<=0, cnt<=0, owner<=g, last<=g,
//    ack_g<=1, busy<=1, state<=SHIFT.
//  SHIFT, one step per edge E1..E_WIDTH:
//  - Add 3 to every acc digit >= 5, using 4-bit wrap.
//  - Shift {acc,sr} left 1; sr MSB enters acc bit 0.
//  - ovf |= the bit shifted out of the acc MSB.
//  - cnt++; after the step where cnt reaches WIDTH, state<=DONE.
//  DONE, at edge E_WIDTH+1: bcd<=acc; overflow<=ovf; valid<=1; state<=IDLE.
//  - valid and busy are both high for one cycle; busy drops with valid.
//  - A new grant occurs at the earliest on the edge after valid rises.
//  - Throughput: one conversion per WIDTH+2 cycles.
//  Latency: ack is high the cycle after E0; valid is high the cycle after E_WIDTH+1.
//  Width rules:
//  - Digits are corrected before each shift; no correction after the final shift.
//  - Truncation keeps the low DIGITS decimal digits exact.
//  - overflow=1 iff the value >= 10^DIGITS.
//  Handshake:
//  - The operand is sampled only at the grant edge.
//  - A requester must drop req in its ack cycle.
//  - A req still high in IDLE after service is treated as a new request.
//  - Dropping req before ack withdraws the request; no ack is produced.
//  - Changes to bin after ack are ignored.
//  Reset mid-operation: abort the conversion; no valid pulse; all outputs return to reset values.
// TESTING
//  T1: req0, bin0=1234 -> ack0 one cycle after grant; valid after WIDTH+1 more edges;
//      bcd=16'h1234, owner=0, overflow=0.
//  T2: bin1=0 and bin1=9999 -> bcd=16'h0000 and 16'h9999, overflow=0, owner=1.
//  T3: bin0=10000 -> bcd=16'h0000, overflow=1.
//      bin0=32'hFFFFFFFF -> bcd=16'h7295, overflow=1.
//  T4: req0 and req1 high together from reset, bin0=5, bin1=42 -> first valid:
//      owner=0, bcd=16'h0005; second valid: owner=1, bcd=16'h0042.
//      Repeat the tie after that -> requester 0 is served.
//  T5: rst pulsed at cnt=10 during bin0=777 -> no valid; busy=0 and bcd=0 next cycle.
//      Re-request -> bcd=16'h0777.
//  T6: req1 held continuously while req0 pulses once -> grants alternate 1,0,1.
//      No request is starved; no conversion starts while busy.

Source files
------------

// File: rtl/bin_to_dec_seq_if.sv
// bin_to_dec_seq_if
//   Request/result bundle between two display requesters and the shared
//   binary-to-BCD converter.
//   Signals:
//     req0/bin0, req1/bin1  request and operand for each requester
//     ack0/ack1             1-cycle pulse when an operand is captured
//     busy                  conversion in progress, through the valid cycle
//     valid                 1-cycle pulse: bcd/overflow/owner are valid
//     owner                 requester id of the current result
//     bcd                   result digits, digit 0 = units in bcd[3:0]
//     overflow              value did not fit in DIGITS decimal digits
//   Modports: master = requester side, slave = converter side.
interface bin_to_dec_seq_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned DIGITS = 4
);
   logic                  req0;
   logic [WIDTH-1:0]      bin0;
   logic                  req1;
   logic [WIDTH-1:0]      bin1;
   logic                  ack0;
   logic                  ack1;
   logic                  busy;
   logic                  valid;
   logic                  owner;
   logic [4*DIGITS-1:0]   bcd;
   logic                  overflow;

   modport master (
      output req0, bin0, req1, bin1,
      input  ack0, ack1, busy, valid, owner, bcd, overflow
   );

   modport slave (
      input  req0, bin0, req1, bin1,
      output ack0, ack1, busy, valid, owner, bcd, overflow
   );
endinterface

// File: rtl/bin_to_dec_seq.sv
// bin_to_dec_seq
//   Iterative binary-to-BCD converter (double dabble, one input bit per clock)
//   shared by two requesters through round-robin arbitration.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous reset, active-high
//     bus  bin_to_dec_seq_if.slave: req/bin in, ack/busy/valid/owner/bcd/overflow out
//   One conversion takes WIDTH+2 cycles from grant edge to the next possible grant.
module bin_to_dec_seq #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned DIGITS = 4
) (
   input  logic            clk,
   input  logic            rst,
   bin_to_dec_seq_if.slave bus
);
   localparam int unsigned BW = 4 * DIGITS;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sr;
   logic [BW-1:0]    acc;
   logic             ovf;
   logic             last;
   logic [CW-1:0]    cnt;

   logic [BW-1:0]    acc_adj;
   logic [BW-1:0]    acc_next;
   logic [WIDTH-1:0] sr_next;
   logic             carry_out;
   logic             gnt;

   // Correct digits first, then shift; whatever leaves the top digit is overflow.
   always_comb begin
      acc_adj = acc;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (acc[4*d +: 4] >= 4'd5) begin
            acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
         end
      end
      {carry_out, acc_next, sr_next} = {acc_adj, sr, 1'b0};
   end

   // A tie goes to the requester that was not served last.
   always_comb begin
      gnt = (bus.req0 && bus.req1) ? ~last : bus.req1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         sr           <= '0;
         acc          <= '0;
         ovf          <= 1'b0;
         cnt          <= '0;
         last         <= 1'b1;
         bus.ack0     <= 1'b0;
         bus.ack1     <= 1'b0;
         bus.busy     <= 1'b0;
         bus.valid    <= 1'b0;
         bus.owner    <= 1'b0;
         bus.bcd      <= '0;
         bus.overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.valid <= 1'b0;
               bus.busy  <= 1'b0;
               if (bus.req0 || bus.req1) begin
                  sr        <= gnt ? bus.bin1 : bus.bin0;
                  acc       <= '0;
                  ovf       <= 1'b0;
                  cnt       <= '0;
                  bus.owner <= gnt;
                  last      <= gnt;
                  bus.ack0  <= ~gnt;
                  bus.ack1  <= gnt;
                  bus.busy  <= 1'b1;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               bus.ack0 <= 1'b0;
               bus.ack1 <= 1'b0;
               acc      <= acc_next;
               sr       <= sr_next;
               ovf      <= ovf | carry_out;
               cnt      <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               bus.bcd      <= acc;
               bus.overflow <= ovf;
               bus.valid    <= 1'b1;
               state        <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bin_to_dec_seq.sv
// tb_bin_to_dec_seq
//   Directed bench for bin_to_dec_seq: table of single-requester conversions
//   with latency checks, plus hand-written sequences for reset abort,
//   tie arbitration and a continuously held request.
module tb_bin_to_dec_seq;
   localparam int unsigned W = 32;
   localparam int unsigned D = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   bin_to_dec_seq_if #(.WIDTH(W), .DIGITS(D)) bus ();

   bin_to_dec_seq #(.WIDTH(W), .DIGITS(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   logic        got_owner[$];
   logic [15:0] got_bcd[$];

   typedef struct {
      logic        sel;
      logic [31:0] bin;
      logic [15:0] exp_bcd;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Called with the DUT able to grant on the next edge.
   task automatic convert(input logic sel, input logic [31:0] val,
                          input logic [15:0] exp_bcd, input logic exp_ovf);
      int  waitc;
      bit  got;
      if (sel) begin bus.req1 = 1'b1; bus.bin1 = val; end
      else     begin bus.req0 = 1'b1; bus.bin0 = val; end
      @(posedge clk); #1;
      chk("ack_latency", sel ? bus.ack1 : bus.ack0, 1);
      chk("ack_other",   sel ? bus.ack0 : bus.ack1, 0);
      chk("busy_at_ack", bus.busy, 1);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      bus.bin0 = ~val;
      bus.bin1 = ~val;
      waitc = 0;
      got   = 0;
      while (!got && waitc < int'(W) + 10) begin
         @(posedge clk); #1;
         waitc++;
         if (waitc == 1) chk("ack_pulse_width", bus.ack0 | bus.ack1, 0);
         if (bus.valid) got = 1;
      end
      chk("valid_latency", waitc, W + 1);
      chk("busy_with_valid", bus.busy, 1);
      chk("bcd", bus.bcd, exp_bcd);
      chk("overflow", bus.overflow, exp_ovf);
      chk("owner", bus.owner, sel);
   endtask

   // Free-running handshake: drop req on ack (req1 optionally held), collect results.
   task automatic run_seq(input int n_valid, input bit hold1,
                          input int raise0_at, input logic [31:0] raise0_bin);
      int cyc;
      bit pb, pv, bad;
      cyc = 0; pb = 0; pv = 0; bad = 0;
      got_owner.delete();
      got_bcd.delete();
      while (got_owner.size() < n_valid && cyc < n_valid * (int'(W) + 2) + 20) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == raise0_at) begin bus.req0 = 1'b1; bus.bin0 = raise0_bin; end
         if ((bus.ack0 || bus.ack1) && pb && !pv) bad = 1;
         if (bus.ack0 && bus.ack1) bad = 1;
         if (bus.ack0) bus.req0 = 1'b0;
         if (bus.ack1 && !hold1) bus.req1 = 1'b0;
         if (bus.valid) begin
            got_owner.push_back(bus.owner);
            got_bcd.push_back(bus.bcd);
         end
         pb = bus.busy;
         pv = bus.valid;
      end
      chk("result_count", got_owner.size(), n_valid);
      chk("grant_while_busy", bad, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      bus.bin0 = '0;
      bus.bin1 = '0;

      vecs[0] = '{1'b0, 32'd1234,       16'h1234, 1'b0};
      vecs[1] = '{1'b1, 32'd0,          16'h0000, 1'b0};
      vecs[2] = '{1'b1, 32'd9999,       16'h9999, 1'b0};
      vecs[3] = '{1'b0, 32'd10000,      16'h0000, 1'b1};
      vecs[4] = '{1'b0, 32'hFFFFFFFF,   16'h7295, 1'b1};
      vecs[5] = '{1'b1, 32'd9,          16'h0009, 1'b0};
      vecs[6] = '{1'b0, 32'd10,         16'h0010, 1'b0};
      vecs[7] = '{1'b1, 32'd99999,      16'h9999, 1'b1};
      vecs[8] = '{1'b0, 32'd1000,       16'h1000, 1'b0};
      vecs[9] = '{1'b1, 32'd123456789,  16'h6789, 1'b1};

      do_reset();
      chk("rst_ack0", bus.ack0, 0);
      chk("rst_ack1", bus.ack1, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_valid", bus.valid, 0);
      chk("rst_owner", bus.owner, 0);
      chk("rst_overflow", bus.overflow, 0);
      chk("rst_bcd", bus.bcd, 0);

      for (int i = 0; i < 10; i++) begin
         convert(vecs[i].sel, vecs[i].bin, vecs[i].exp_bcd, vecs[i].exp_ovf);
      end

      // Reset at cnt=10 aborts the conversion and clears held results.
      bus.req0 = 1'b1;
      bus.bin0 = 32'd777;
      @(posedge clk); #1;
      chk("abort_ack0", bus.ack0, 1);
      bus.req0 = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", bus.busy, 0);
      chk("abort_bcd", bus.bcd, 0);
      chk("abort_valid", bus.valid, 0);
      chk("abort_overflow", bus.overflow, 0);
      seen = 0;
      repeat (W + 6) begin
         @(posedge clk); #1;
         if (bus.valid || bus.busy) seen = 1;
      end
      chk("abort_no_valid", seen, 0);
      convert(1'b0, 32'd777, 16'h0777, 1'b0);

      // Tie from reset: requester 0 first, then 1; the repeated tie goes to 0.
      do_reset();
      bus.req0 = 1'b1; bus.bin0 = 32'd5;
      bus.req1 = 1'b1; bus.bin1 = 32'd42;
      run_seq(2, 1'b0, -1, 32'd0);
      if (got_owner.size() == 2) begin
         chk("tie1_owner_a", got_owner[0], 0);
         chk("tie1_bcd_a",   got_bcd[0],   16'h0005);
         chk("tie1_owner_b", got_owner[1], 1);
         chk("tie1_bcd_b",   got_bcd[1],   16'h0042);
      end
      bus.req0 = 1'b1; bus.bin0 = 32'd5;
      bus.req1 = 1'b1; bus.bin1 = 32'd42;
      run_seq(2, 1'b0, -1, 32'd0);
      if (got_owner.size() == 2) begin
         chk("tie2_owner_a", got_owner[0], 0);
         chk("tie2_owner_b", got_owner[1], 1);
      end

      // req1 held throughout, req0 arrives once mid-conversion: 1,0,1.
      do_reset();
      bus.req1 = 1'b1; bus.bin1 = 32'd321;
      run_seq(3, 1'b1, 5, 32'd55);
      bus.req1 = 1'b0;
      if (got_owner.size() == 3) begin
         chk("hold_owner_a", got_owner[0], 1);
         chk("hold_bcd_a",   got_bcd[0],   16'h0321);
         chk("hold_owner_b", got_owner[1], 0);
         chk("hold_bcd_b",   got_bcd[1],   16'h0055);
         chk("hold_owner_c", got_owner[2], 1);
         chk("hold_bcd_c",   got_bcd[2],   16'h0321);
      end
      @(posedge clk); #1;
      chk("hold_idle_busy", bus.busy, 0);
      chk("hold_idle_valid", bus.valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
